// File: rtl/sbox_scheduler_pkg.sv
// sbox_scheduler_pkg: shared widths, FSM encoding, grant constants and the AES S-box function.
package sbox_scheduler_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_ST  = 2'd1,
        RUN_KEY = 2'd2
    } state_t;

    localparam logic GRANT_ST  = 1'b0;
    localparam logic GRANT_KEY = 1'b1;

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); maps 0 to 0 as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int k = 0; k < 7; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] s_box_func(input logic [7:0] b, input logic enc);
        logic [7:0] x;
        if (enc) begin
            x = gf_inv(b);
            return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
        end
        return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/sbox_scheduler_lane.sv
// sbox_lane: one combinational S-box lookup, forward when enc=1, inverse otherwise.
module sbox_lane
    import sbox_scheduler_pkg::*;
(
    input  logic [7:0] din,
    input  logic       enc,
    output logic [7:0] dout
);

    assign dout = s_box_func(din, enc);

endmodule

// File: rtl/sbox_scheduler.sv
// sbox_scheduler: shares LANES S-box lanes between the state datapath and the key expander.
// Optional SBOX_FLUSH_EN adds a flush input that abandons the running job.
module sbox_scheduler
    import sbox_scheduler_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic                   st_enc,
    input  logic [AES_STATE_W-1:0] st_in,
    output logic                   st_done,
    output logic [AES_STATE_W-1:0] st_out,
    input  logic                   key_valid,
    output logic                   key_ready,
    input  logic [AES_WORD_W-1:0]  key_in,
    output logic                   key_done,
    output logic [AES_WORD_W-1:0]  key_out,
    output logic                   busy
`ifdef SBOX_FLUSH_EN
    ,
    input  logic                   flush
`endif
);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("sbox_scheduler: LANES must be 1, 2 or 4");
    end

    state_t                 state, state_nx;
    logic [3:0]             idx;
    logic                   fin;
    logic                   enc_r;
    logic                   last_grant;
    logic [AES_STATE_W-1:0] work, sub;
    logic [7:0]             lane_in  [LANES];
    logic [7:0]             lane_out [LANES];
    logic                   fl, rdy, accept, pick_key, last_grp;

`ifdef SBOX_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_in[i] = work[{idx + 4'(i), 3'b000} +: 8];
        sbox_lane u_lane (.din(lane_in[i]), .enc(enc_r), .dout(lane_out[i]));
    end

    always_comb begin
        sub = work;
        for (int l = 0; l < LANES; l++) sub[{idx + 4'(l), 3'b000} +: 8] = lane_out[l];
    end

    assign busy      = state != IDLE;
    assign rdy       = !busy && !rst && !fl;
    assign st_ready  = rdy;
    assign key_ready = rdy;
    // Round robin on a tie: the requester not served last time wins
    assign pick_key  = key_valid && (!st_valid || last_grant == GRANT_ST);
    assign accept    = rdy && (st_valid || key_valid);
    assign last_grp  = idx == (state == RUN_KEY ? 4'(4 - LANES) : 4'(16 - LANES));

    always_comb begin
        state_nx = state;
        if (fl) state_nx = IDLE;
        else if (accept) state_nx = pick_key ? RUN_KEY : RUN_ST;
        else if (fin) state_nx = IDLE;
    end

    // fin marks the extra cycle between the last substitution and the done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            fin        <= 1'b0;
            enc_r      <= 1'b0;
            work       <= '0;
            last_grant <= GRANT_ST;
            st_done    <= 1'b0;
            key_done   <= 1'b0;
            st_out     <= '0;
            key_out    <= '0;
        end else begin
            state    <= state_nx;
            st_done  <= 1'b0;
            key_done <= 1'b0;
            if (fl) begin
                fin <= 1'b0;
            end else if (accept) begin
                work  <= pick_key ? AES_STATE_W'(key_in) : st_in;
                enc_r <= pick_key || st_enc;
                idx   <= '0;
                fin   <= 1'b0;
            end else if (fin) begin
                fin <= 1'b0;
                if (state == RUN_KEY) begin
                    key_done   <= 1'b1;
                    key_out    <= work[AES_WORD_W-1:0];
                    last_grant <= GRANT_KEY;
                end else begin
                    st_done    <= 1'b1;
                    st_out     <= work;
                    last_grant <= GRANT_ST;
                end
            end else if (busy) begin
                work <= sub;
                if (last_grp) fin <= 1'b1;
                else idx <= idx + 4'(LANES);
            end
        end
    end

endmodule

// File: tb/tb_sbox_scheduler.sv
// tb_sbox_scheduler: randomized self-checking bench against a table-driven S-box model.
module tb_sbox_scheduler;

    localparam int L = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         st_valid = 1'b0, st_enc = 1'b0, key_valid = 1'b0, flush = 1'b0;
    logic         st_ready, key_ready, st_done, key_done, busy;
    logic [127:0] st_in = '0, st_out;
    logic [31:0]  key_in = '0, key_out;

    int           pass_cnt = 0;
    int           total = 0;
    logic [7:0]   fwd [256];
    logic [7:0]   inv [256];
    bit           prev_key = 1'b0;

    always #5 clk = ~clk;

    sbox_scheduler #(.LANES(L)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_enc(st_enc), .st_in(st_in),
        .st_done(st_done), .st_out(st_out),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .key_done(key_done), .key_out(key_out),
        .busy(busy)
`ifdef SBOX_FLUSH_EN
        , .flush(flush)
`endif
    );

    // Tables built by walking the generator 3 of GF(2^8) and its inverse in lockstep
    task automatic build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            fwd[p] = x ^ 8'h63;
        end while (p != 8'h01);
        fwd[0] = 8'h63;
        for (int k = 0; k < 256; k++) inv[fwd[k]] = 8'(k);
    endtask

    function automatic logic [127:0] model_sub(input logic [127:0] d, input bit enc, input int nb);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < nb; k++) r[8*k +: 8] = enc ? fwd[d[8*k +: 8]] : inv[d[8*k +: 8]];
        return r;
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (st_done || key_done) break;
        end
    endtask

    task automatic do_job(input bit k, input bit enc, input logic [127:0] d,
                          output int lat, output logic [127:0] q);
        int w = 0;
        st_enc = enc;
        if (k) begin key_valid = 1'b1; key_in = d[31:0]; end
        else begin st_valid = 1'b1; st_in = d; end
        while (!(k ? key_ready : st_ready) && w < 100) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        st_valid = 1'b0; key_valid = 1'b0;
        st_in = {4{$urandom}}; key_in = $urandom; st_enc = 1'($urandom);
        wait_done(lat);
        q = k ? {96'b0, key_out} : st_out;
        prev_key = k;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        total++; if ({st_ready, key_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {st_ready, key_ready}); else pass_cnt++;
        total++; if ({busy, st_done, key_done} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {busy, st_done, key_done}); else pass_cnt++;
        total++; if (st_out !== '0) $display("FAIL reset_st_out got=%h exp=0", st_out); else pass_cnt++;
        total++; if (key_out !== '0) $display("FAIL reset_key_out got=%h exp=0", key_out); else pass_cnt++;
        rst = 1'b0;
        prev_key = 1'b0;
        @(posedge clk); #1;
        total++; if ({st_ready, key_ready} !== 2'b11) $display("FAIL idle_ready got=%b exp=11", {st_ready, key_ready}); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [127:0] a;
        logic [31:0]  b, c;
        int           lat;
        a = {4{$urandom}}; b = $urandom; c = $urandom;
        st_in = a; st_enc = 1'b1; key_in = b;
        st_valid = 1'b1; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0; key_in = $urandom;
        wait_done(lat);
        total++; if ({st_done, key_done} !== 2'b01) $display("FAIL rr_first got=%b exp=01", {st_done, key_done}); else pass_cnt++;
        total++; if (lat !== 4 / L + 1) $display("FAIL rr_key_lat got=%0d exp=%0d", lat, 4 / L + 1); else pass_cnt++;
        total++; if (key_out !== model_sub({96'b0, b}, 1'b1, 4)) $display("FAIL rr_key_out got=%h exp=%h", key_out, model_sub({96'b0, b}, 1'b1, 4)); else pass_cnt++;
        total++; if (st_ready !== 1'b1) $display("FAIL rr_ready_in_done got=%b exp=1", st_ready); else pass_cnt++;
        key_valid = 1'b1; key_in = c;
        @(posedge clk); #1;
        st_valid = 1'b0; st_in = {4{$urandom}}; st_enc = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL rr_b2b_busy got=%b exp=1", busy); else pass_cnt++;
        wait_done(lat);
        total++; if ({st_done, key_done} !== 2'b10) $display("FAIL rr_second got=%b exp=10", {st_done, key_done}); else pass_cnt++;
        total++; if (st_out !== model_sub(a, 1'b1, 16)) $display("FAIL rr_st_out got=%h exp=%h", st_out, model_sub(a, 1'b1, 16)); else pass_cnt++;
        @(posedge clk); #1;
        key_valid = 1'b0;
        wait_done(lat);
        total++; if (key_out !== model_sub({96'b0, c}, 1'b1, 4)) $display("FAIL rr_key2_out got=%h exp=%h", key_out, model_sub({96'b0, c}, 1'b1, 4)); else pass_cnt++;
        prev_key = 1'b1;
    endtask

    task automatic test_vectors();
        int           lat;
        logic [127:0] q;
        do_job(1'b0, 1'b1, 128'h00112233445566778899AABBCCDDEEFF, lat, q);
        total++; if (lat !== 16 / L + 1) $display("FAIL fwd_lat got=%0d exp=%0d", lat, 16 / L + 1); else pass_cnt++;
        total++; if (q !== 128'h638293C31BFC33F5C4EEACEA4BC12816) $display("FAIL fwd_vec got=%h exp=638293c31bfc33f5c4eeacea4bc12816", q); else pass_cnt++;
        do_job(1'b0, 1'b0, 128'h638293C31BFC33F5C4EEACEA4BC12816, lat, q);
        total++; if (q !== 128'h00112233445566778899AABBCCDDEEFF) $display("FAIL inv_vec got=%h exp=00112233445566778899aabbccddeeff", q); else pass_cnt++;
        do_job(1'b1, 1'b0, {96'b0, 32'hCF4F3C09}, lat, q);
        total++; if (lat !== 4 / L + 1) $display("FAIL key_lat got=%0d exp=%0d", lat, 4 / L + 1); else pass_cnt++;
        total++; if (q[31:0] !== 32'h8A84EB01) $display("FAIL key_vec got=%h exp=8a84eb01", q[31:0]); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            logic [127:0] a;
            logic [31:0]  b;
            logic [1:0]   m;
            bit           e, first_key, cur;
            int           lat, n;
            m = 2'($urandom_range(1, 3)); a = {4{$urandom}}; b = $urandom; e = 1'($urandom);
            st_in = a; st_enc = e; key_in = b;
            st_valid = m[0]; key_valid = m[1];
            first_key = m[1] && (!m[0] || !prev_key);
            n = int'(m[0]) + int'(m[1]);
            for (int j = 0; j < n; j++) begin
                cur = (j == 0) ? first_key : !first_key;
                @(posedge clk); #1;
                if (cur) begin key_valid = 1'b0; key_in = $urandom; end
                else begin st_valid = 1'b0; st_in = {4{$urandom}}; st_enc = 1'($urandom); end
                wait_done(lat);
                total++; if ({st_done, key_done} !== (cur ? 2'b01 : 2'b10)) $display("FAIL rnd_grant it=%0d got=%b exp=%b", it, {st_done, key_done}, cur ? 2'b01 : 2'b10); else pass_cnt++;
                total++; if (lat !== (cur ? 4 : 16) / L + 1) $display("FAIL rnd_lat it=%0d got=%0d exp=%0d", it, lat, (cur ? 4 : 16) / L + 1); else pass_cnt++;
                if (cur) begin
                    total++; if (key_out !== model_sub({96'b0, b}, 1'b1, 4)) $display("FAIL rnd_key it=%0d got=%h exp=%h", it, key_out, model_sub({96'b0, b}, 1'b1, 4)); else pass_cnt++;
                end else begin
                    total++; if (st_out !== model_sub(a, e, 16)) $display("FAIL rnd_st it=%0d got=%h exp=%h", it, st_out, model_sub(a, e, 16)); else pass_cnt++;
                end
                prev_key = cur;
            end
        end
    endtask

    task automatic test_reset_mid_job();
        int           seen = 0, lat;
        logic [127:0] a, q;
        st_in = {4{$urandom}}; st_enc = 1'b1; st_valid = 1'b1;
        @(posedge clk); #1;
        st_valid = 1'b0;
        repeat (7) @(posedge clk); #1;
        rst = 1'b1; #1;
        total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy); else pass_cnt++;
        total++; if (st_out !== '0) $display("FAIL mid_rst_st_out got=%h exp=0", st_out); else pass_cnt++;
        total++; if (st_ready !== 1'b0) $display("FAIL mid_rst_ready got=%b exp=0", st_ready); else pass_cnt++;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        prev_key = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (st_done || key_done) seen++; end
        total++; if (seen !== 0) $display("FAIL mid_rst_no_done got=%0d exp=0", seen); else pass_cnt++;
        a = {4{$urandom}};
        do_job(1'b0, 1'b1, a, lat, q);
        total++; if (q !== model_sub(a, 1'b1, 16)) $display("FAIL mid_rst_next got=%h exp=%h", q, model_sub(a, 1'b1, 16)); else pass_cnt++;
        total++; if (lat !== 16 / L + 1) $display("FAIL mid_rst_lat got=%0d exp=%0d", lat, 16 / L + 1); else pass_cnt++;
    endtask

`ifdef SBOX_FLUSH_EN
    task automatic test_flush();
        int           seen = 0, lat;
        logic [127:0] q;
        do_job(1'b0, 1'b1, {4{$urandom}}, lat, q);
        st_in = {4{$urandom}}; st_enc = 1'b1; st_valid = 1'b1;
        @(posedge clk); #1;
        st_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL flush_busy got=%b exp=0", busy); else pass_cnt++;
        repeat (20) begin @(posedge clk); #1; if (st_done || key_done) seen++; end
        total++; if (seen !== 0) $display("FAIL flush_no_done got=%0d exp=0", seen); else pass_cnt++;
        total++; if (st_out !== q) $display("FAIL flush_st_out got=%h exp=%h", st_out, q); else pass_cnt++;
    endtask
`endif

    initial begin
        build_tables();
        test_reset();
        test_round_robin();
        test_vectors();
        test_random();
        test_reset_mid_job();
`ifdef SBOX_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
